// File: rtl/range_frame_gen.sv
// Range-finder frame source: emits one framed burst of ramp or LFSR samples per
// accepted start and publishes the min/max/range of the completed frame.
module range_frame_gen #(
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     LEN_WIDTH = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     base,
  input  logic [WIDTH-1:0]     step,
  input  logic [LEN_WIDTH-1:0] length,
  output logic [WIDTH-1:0]     data_out,
  output logic                 go,
  output logic                 finish,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_error,
  output logic [WIDTH-1:0]     exp_min,
  output logic [WIDTH-1:0]     exp_max,
  output logic [WIDTH-1:0]     exp_range
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FIRST = 3'd1,
    BODY  = 3'd2,
    LAST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(2);

  state_t               state;
  logic                 mode_q;
  logic [WIDTH-1:0]     base_q;
  logic [WIDTH-1:0]     step_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]     sample;
  logic [WIDTH-1:0]     min_q;
  logic [WIDTH-1:0]     max_q;
  logic [WIDTH-1:0]     seed_c;

  // Successor of a sample under the latched generator mode.
  function automatic logic [WIDTH-1:0] next_sample(input logic m,
                                                   input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] inc);
    if (m) return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    return s + inc;
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  always_comb begin
    seed_c = base_q;
    if (mode_q && (base_q == '0)) seed_c = WIDTH'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      base_q    <= '0;
      step_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      sample    <= '0;
      min_q     <= '0;
      max_q     <= '0;
      data_out  <= '0;
      go        <= 1'b0;
      finish    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_error <= 1'b0;
      exp_min   <= '0;
      exp_max   <= '0;
      exp_range <= '0;
    end else begin
      go        <= 1'b0;
      finish    <= 1'b0;
      done      <= 1'b0;
      cfg_error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length >= MIN_LEN) begin
              mode_q <= mode;
              base_q <= base;
              step_q <= step;
              len_q  <= length;
              state  <= FIRST;
            end else begin
              cfg_error <= 1'b1;
            end
          end
        end
        FIRST: begin
          go       <= 1'b1;
          busy     <= 1'b1;
          data_out <= seed_c;
          sample   <= next_sample(mode_q, seed_c, step_q);
          min_q    <= seed_c;
          max_q    <= seed_c;
          cnt      <= LEN_WIDTH'(1);
          state    <= (len_q > MIN_LEN) ? BODY : LAST;
        end
        BODY: begin
          data_out <= sample;
          sample   <= next_sample(mode_q, sample, step_q);
          if (sample < min_q) min_q <= sample;
          if (sample > max_q) max_q <= sample;
          cnt      <= cnt + LEN_WIDTH'(1);
          // cnt is the index of the sample going out now; the next one is the last.
          if (cnt == (len_q - MIN_LEN)) state <= LAST;
        end
        LAST: begin
          finish   <= 1'b1;
          data_out <= sample;
          if (sample < min_q) min_q <= sample;
          if (sample > max_q) max_q <= sample;
          state    <= DONE;
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          exp_min   <= min_q;
          exp_max   <= max_q;
          exp_range <= max_q - min_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_frame_gen.sv
// Scoreboard bench for range_frame_gen: driver pushes expected samples/frame
// summaries from a reference model; a negedge monitor pops and compares.
module tb_range_frame_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode  = 1'b0;
  logic [7:0] base  = '0;
  logic [7:0] step  = '0;
  logic [7:0] length = '0;
  logic [7:0] data_out, exp_min, exp_max, exp_range;
  logic       go, finish, busy, done, cfg_error;

  range_frame_gen #(.WIDTH(8), .LEN_WIDTH(8), .LFSR_TAPS(8'hB8)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .base(base),
    .step(step), .length(length), .data_out(data_out), .go(go), .finish(finish),
    .busy(busy), .done(done), .cfg_error(cfg_error), .exp_min(exp_min),
    .exp_max(exp_max), .exp_range(exp_range)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] data; logic go; logic fin; } samp_t;
  typedef struct { logic [7:0] mn; logic [7:0] mx; int len; logic [7:0] last; } frm_t;

  samp_t sq[$];
  frm_t  fq[$];
  int tests = 0, fails = 0;
  int done_cnt = 0, err_cnt = 0, go_cnt = 0, pend_err = 0, busy_run = 0;
  int cyc = 0, done_cyc = 0, go_cyc = 0;
  logic [7:0] last_mn = '0, last_mx = '0, last_rg = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  // Reference model: sample k of the frame, min/max over the whole frame.
  task automatic push_frame(input logic m, input logic [7:0] b, input logic [7:0] s,
                            input logic [7:0] l);
    logic [7:0] v, lf;
    frm_t f;
    lf = (b == 8'd0) ? 8'd1 : b;
    f.mn = 8'hFF; f.mx = 8'h00; f.len = int'(l);
    for (int k = 0; k < int'(l); k++) begin
      v = m ? lf : 8'(int'(b) + k * int'(s));
      sq.push_back('{data: v, go: (k == 0), fin: (k == int'(l) - 1)});
      if (v < f.mn) f.mn = v;
      if (v > f.mx) f.mx = v;
      f.last = v;
      lf = lfsr_next(lf);
    end
    fq.push_back(f);
  endtask

  task automatic wait_for(input int td, input int te, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= td && err_cnt >= te) return;
      @(posedge clock); #2;
    end
    fail_now({"timeout_", name});
  endtask

  task automatic run_frame(input logic m, input logic [7:0] b, input logic [7:0] s,
                           input logic [7:0] l, input string name);
    int td, te;
    @(posedge clock); #2;
    mode = m; base = b; step = s; length = l; start = 1'b1;
    td = done_cnt; te = err_cnt;
    if (l >= 8'd2) begin push_frame(m, b, s, l); td++; end
    else begin pend_err++; te++; end
    @(posedge clock); #2;
    start = 1'b0;
    wait_for(td, te, int'(l) + 10, name);
  endtask

  always @(negedge clock) begin : monitor
    samp_t e;
    frm_t f;
    if (!reset) begin
      if (busy) begin
        busy_run++;
        if (go) begin go_cnt++; go_cyc = cyc; end
        if (sq.size() == 0) fail_now("unexpected_sample");
        else begin
          e = sq.pop_front();
          check("data_out", 32'(data_out), 32'(e.data));
          check("go", 32'(go), 32'(e.go));
          check("finish", 32'(finish), 32'(e.fin));
        end
      end else begin
        check("strobes_while_idle", {30'd0, go, finish}, 32'd0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_vs_cfg_error", 32'(cfg_error), 32'd0);
        if (fq.size() == 0) fail_now("unexpected_done");
        else begin
          f = fq.pop_front();
          check("exp_min", 32'(exp_min), 32'(f.mn));
          check("exp_max", 32'(exp_max), 32'(f.mx));
          check("exp_range", 32'(exp_range), 32'(8'(f.mx - f.mn)));
          check("busy_cycles", 32'(busy_run), 32'(f.len));
          check("data_hold", 32'(data_out), 32'(f.last));
          last_mn = f.mn; last_mx = f.mx; last_rg = 8'(f.mx - f.mn);
        end
        busy_run = 0;
      end
      if (cfg_error) begin
        err_cnt++;
        if (pend_err == 0) fail_now("unexpected_cfg_error");
        else pend_err--;
        check("cfg_err_busy", 32'(busy), 32'd0);
        check("cfg_err_exp_min", 32'(exp_min), 32'(last_mn));
        check("cfg_err_exp_max", 32'(exp_max), 32'(last_mx));
        check("cfg_err_exp_range", 32'(exp_range), 32'(last_rg));
      end
    end
  end

  initial begin
    int d1, g0;
    logic [7:0] l;

    repeat (2) @(posedge clock);
    #2;
    check("reset_outputs", {data_out, exp_min, exp_max, exp_range},  32'd0);
    check("reset_strobes", {27'd0, go, finish, busy, done, cfg_error}, 32'd0);
    reset = 1'b0;

    run_frame(1'b0, 8'd10, 8'd3, 8'd4, "ramp");
    run_frame(1'b0, 8'd250, 8'd3, 8'd3, "wrap");
    run_frame(1'b1, 8'd0, 8'd0, 8'd3, "lfsr_zero");
    run_frame(1'b0, 8'd7, 8'd1, 8'd1, "len1");
    run_frame(1'b0, 8'd7, 8'd1, 8'd0, "len0");
    run_frame(1'b1, 8'h5A, 8'd0, 8'd2, "len2");
    run_frame(1'b0, 8'd100, 8'd7, 8'd255, "len255");

    // start held high: second frame follows only after DONE -> IDLE
    @(posedge clock); #2;
    mode = 1'b0; base = 8'd40; step = 8'd200; length = 8'd3; start = 1'b1;
    push_frame(1'b0, 8'd40, 8'd200, 8'd3);
    push_frame(1'b0, 8'd40, 8'd200, 8'd3);
    g0 = go_cnt;
    wait_for(done_cnt + 1, err_cnt, 20, "held_first");
    d1 = done_cyc;
    for (int i = 0; i < 20 && go_cnt < g0 + 2; i++) begin @(posedge clock); #2; end
    start = 1'b0;
    check("held_go_after_done", 32'(go_cyc - d1), 32'd2);
    wait_for(done_cnt + 1, err_cnt, 20, "held_second");

    // async reset in the middle of a body
    @(posedge clock); #2;
    mode = 1'b0; base = 8'd3; step = 8'd5; length = 8'd20; start = 1'b1;
    push_frame(1'b0, 8'd3, 8'd5, 8'd20);
    @(posedge clock); #2;
    start = 1'b0;
    for (int i = 0; i < 30 && busy_run < 6; i++) begin @(posedge clock); #2; end
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check("rst_mid_strobes", {29'd0, go, finish, busy}, 32'd0);
    check("rst_mid_exp", {8'd0, exp_min, exp_max, exp_range}, 32'd0);
    sq.delete(); fq.delete();
    busy_run = 0; pend_err = 0;
    last_mn = '0; last_mx = '0; last_rg = '0;
    @(posedge clock); #2;
    reset = 1'b0;
    run_frame(1'b1, 8'h81, 8'd0, 8'd6, "after_reset");

    for (int n = 0; n < 25; n++) begin
      l = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(2, 40));
      run_frame(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), l, "random");
    end

    repeat (3) @(posedge clock);
    #2;
    check("leftover_samples", 32'(sq.size()), 32'd0);
    check("leftover_frames", 32'(fq.size()), 32'd0);
    check("leftover_cfg_errors", 32'(pend_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
